multi_operand_adder_display: RTL



---
 rtl/multi_operand_adder_display_pkg.sv | 18 +
 rtl/multi_operand_adder_display_if.sv | 25 ++
 rtl/multi_operand_adder_display_hex_to_seven_seg.sv | 9 +
 rtl/multi_operand_adder_display.sv | 107 ++++++++++
 4 files changed

// File: rtl/multi_operand_adder_display_pkg.sv
// Shared types and constants for the multi-operand adder with seven-segment display.
package adder_display_pkg;

  typedef enum logic [1:0] {
    IDLE,
    ACCUM,
    DONE
  } adder_state_t;

  // Active-low segments {g,f,e,d,c,b,a}, indexed by hex value 0..F.
  localparam logic [6:0] HEX_SEG_N [16] = '{
    7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
    7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
    7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
    7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110
  };

endpackage

// File: rtl/multi_operand_adder_display_if.sv
// Operand/handshake/display bundle between the switch inputs and the adder block.
interface multi_operand_adder_display_if #(
  parameter int WIDTH   = 4,
  parameter int NUM_OPS = 2
);
  localparam int SUM_W = WIDTH + $clog2(NUM_OPS);

  logic [NUM_OPS-1:0][WIDTH-1:0] ops;
  logic                          start;
  logic                          busy;
  logic                          done;
  logic [SUM_W-1:0]              sum;
  logic [6:0]                    seg_n;
  logic [NUM_OPS-1:0]            digit_en_n;

  modport master (
    output ops, start,
    input  busy, done, sum, seg_n, digit_en_n
  );

  modport slave (
    input  ops, start,
    output busy, done, sum, seg_n, digit_en_n
  );
endinterface

// File: rtl/multi_operand_adder_display_hex_to_seven_seg.sv
// Combinational hex digit to active-low seven-segment pattern.
module hex_to_seven_seg
  import adder_display_pkg::*;
(
  input  logic [3:0] hex,
  output logic [6:0] seg_n
);
  assign seg_n = HEX_SEG_N[hex];
endmodule

// File: rtl/multi_operand_adder_display.sv
// Sequential NUM_OPS-operand accumulator with start/done handshake, plus a
// free-running scan that multiplexes the live operands onto one display.
module multi_operand_adder_display
  import adder_display_pkg::*;
#(
  parameter int WIDTH    = 4,
  parameter int NUM_OPS  = 2,
  parameter int DIV_BITS = 16
) (
  input  logic                         clk,
  input  logic                         reset,
  multi_operand_adder_display_if.slave bus
);
  localparam int SUM_W = WIDTH + $clog2(NUM_OPS);
  localparam int IDX_W = $clog2(NUM_OPS);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_OPS - 1);

  adder_state_t                  state_q, state_d;
  logic [NUM_OPS-1:0][WIDTH-1:0] snap_q, snap_d;
  logic [SUM_W-1:0]              acc_q, acc_d;
  logic [SUM_W-1:0]              sum_q, sum_d;
  logic [SUM_W-1:0]              addend;
  logic [IDX_W-1:0]              idx_q, idx_d;

  logic [DIV_BITS-1:0]           refresh_q, refresh_d;
  logic [IDX_W-1:0]              digit_q, digit_d;
  logic [NUM_OPS-1:0]            digit_en_n_q, digit_en_n_d;
  logic [3:0]                    nibble;
  logic [6:0]                    seg_n;

  always_comb begin
    state_d = state_q;
    snap_d  = snap_q;
    acc_d   = acc_q;
    idx_d   = idx_q;
    sum_d   = sum_q;
    addend  = SUM_W'(snap_q[idx_q]);
    unique case (state_q)
      IDLE: begin
        if (bus.start) begin
          state_d = ACCUM;
          snap_d  = bus.ops;
          acc_d   = '0;
          idx_d   = '0;
        end
      end
      ACCUM: begin
        acc_d = acc_q + addend;
        idx_d = idx_q + IDX_W'(1);
        // The last operand goes straight into sum so done can follow next cycle.
        if (idx_q == LAST_IDX) begin
          sum_d   = acc_q + addend;
          state_d = DONE;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    refresh_d    = refresh_q + DIV_BITS'(1);
    digit_d      = digit_q;
    digit_en_n_d = digit_en_n_q;
    if (&refresh_q) begin
      digit_d      = (digit_q == LAST_IDX) ? '0 : digit_q + IDX_W'(1);
      digit_en_n_d = ~(NUM_OPS'(1) << digit_d);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= IDLE;
      snap_q       <= '0;
      acc_q        <= '0;
      idx_q        <= '0;
      sum_q        <= '0;
      refresh_q    <= '0;
      digit_q      <= '0;
      digit_en_n_q <= ~(NUM_OPS'(1));
    end else begin
      state_q      <= state_d;
      snap_q       <= snap_d;
      acc_q        <= acc_d;
      idx_q        <= idx_d;
      sum_q        <= sum_d;
      refresh_q    <= refresh_d;
      digit_q      <= digit_d;
      digit_en_n_q <= digit_en_n_d;
    end
  end

  // Display follows the live operands, not the snapshot.
  assign nibble = 4'(bus.ops[digit_q]);

  hex_to_seven_seg u_hex (
    .hex   (nibble),
    .seg_n (seg_n)
  );

  assign bus.busy       = (state_q == ACCUM);
  assign bus.done       = (state_q == DONE);
  assign bus.sum        = sum_q;
  assign bus.seg_n      = seg_n;
  assign bus.digit_en_n = digit_en_n_q;

endmodule
